credit_sender: RTL

Upstream counterpart of the credit receiver. Accepts a valid/ready stream from a local producer, forwards it across a credit-based link, and holds a credit counter: decremented on each forwarded transfer, incremented on each credit return. The block also runs the link reset handshake, reporting its own reset state to the receiver and holding traffic while the receiver is in reset.

---
 rtl/credit_pkg.sv | 7 +
 rtl/credit_counter.sv | 30 +++
 rtl/credit_sender.sv | 63 ++++++
 3 files changed

// File: rtl/credit_pkg.sv
// credit_pkg: state enum and width helper shared by the credit sender and receiver
package credit_pkg;
  typedef enum logic [1:0] {RESET, HOLD, ACTIVE} credit_state_e;
  function automatic int credit_width(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/credit_counter.sv
// credit_counter: saturating up/down credit counter with load and sticky overflow flag
module credit_counter import credit_pkg::*; #(
  parameter int MAX = 8,
  parameter int CW = credit_width(MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          overflow
);
  logic sat_hi, sat_lo;
  logic [CW-1:0] count_next;
  always_comb begin
    sat_hi = inc & ~dec & (count == CW'(MAX));
    sat_lo = dec & ~inc & (count == '0);
    count_next = load ? load_val : (sat_hi | sat_lo) ? count : count + CW'(inc) - CW'(dec);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      overflow <= overflow | (sat_hi & ~load);
    end
endmodule

// File: rtl/credit_sender.sv
// credit_sender: credit-based link sender with reset handshake; CREDIT_SENDER_POP_REG_EN registers the pop path
module credit_sender import credit_pkg::*; #(
  parameter int MAX_CREDITS = 8,
  parameter int DATA_WIDTH = 8,
  localparam int CW = credit_width(MAX_CREDITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  pop_credit,
  output logic                  pop_credit_stall,
  output logic                  pop_sender_in_reset,
  input  logic                  pop_receiver_in_reset,
  input  logic [CW-1:0]         credit_initial,
  input  logic [CW-1:0]         credit_withhold,
  output logic [CW-1:0]         credit_count,
  output logic                  credit_available,
  output logic                  credit_overflow
);
  credit_state_e state, state_next;
  logic fire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RESET;
    else state <= state_next;
  always_comb state_next = (state == RESET || pop_receiver_in_reset) ? HOLD : ACTIVE;
  always_comb begin
    pop_sender_in_reset = state == RESET;
    pop_credit_stall = state != ACTIVE;
    credit_available = credit_count > credit_withhold;
    push_ready = (state == ACTIVE) & credit_available;
    fire = push_valid & push_ready;
  end
  // credits arriving outside ACTIVE are dropped; the count reloads on every HOLD exit
  credit_counter #(.MAX(MAX_CREDITS)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == HOLD && state_next == ACTIVE),
    .inc      (state == ACTIVE && pop_credit),
    .dec      (fire),
    .load_val (credit_initial),
    .count    (credit_count),
    .overflow (credit_overflow)
  );
`ifdef CREDIT_SENDER_POP_REG_EN
  logic keep;
  assign keep = fire & (state_next == ACTIVE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pop_valid <= 1'b0;
      pop_data <= '0;
    end else begin
      pop_valid <= keep;
      pop_data <= keep ? push_data : '0;
    end
`else
  assign pop_valid = fire;
  assign pop_data = push_data;
`endif
endmodule
